alu_arbiter: RTL and testbench

Shares the single combinational PDP-11 ALU between two requesters: the execute unit (port X, full opcode set and condition codes) and the address/PC unit (port P, address arithmetic such as `INC2`, `DEC2` and `BRANCH`). The block registers the granted operands, drives the ALU from those registers and registers the result. It delivers one result per cycle with fixed 2-cycle latency. It sits between the control sequencer and the ALU instance in the CPU core.

---
 rtl/alu_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared PDP-11 ALU: registered operand and result stages, fixed 2-cycle latency.
// Optional build macro ALU_ARB_RR_EN selects round-robin arbitration instead of fixed priority with starvation escape.
module alu_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        x_req,
    input  logic        x_lock,
    input  logic [9:0]  x_op,
    input  logic [15:0] x_a,
    input  logic [15:0] x_b,
    input  logic [7:0]  x_ps,
    output logic        x_gnt,
    output logic        x_done,
    output logic [15:0] x_d,
    output logic [7:0]  x_psr,
    input  logic        p_req,
    input  logic [9:0]  p_op,
    input  logic [15:0] p_a,
    input  logic [15:0] p_b,
    output logic        p_gnt,
    output logic        p_done,
    output logic [15:0] p_d,
    output logic [9:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [7:0]  alu_ps,
    input  logic [15:0] alu_d,
    input  logic [7:0]  alu_psr
);

    localparam logic OWN_X = 1'b0;
    localparam logic OWN_P = 1'b1;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("alu_arbiter: STARVE_MAX must be in 1..15");
    end

    logic x_win;
    logic p_win;
    logic s1_valid;
    logic s1_owner;

`ifdef ALU_ARB_RR_EN
    logic last_owner;

    always_comb begin
        x_win = 1'b0;
        p_win = 1'b0;
        if (x_lock) begin
            x_win = x_req;
        end else if (x_req && p_req) begin
            x_win = (last_owner == OWN_P);
            p_win = (last_owner == OWN_X);
        end else begin
            x_win = x_req;
            p_win = p_req;
        end
    end

    // Resets to P so that X takes the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner <= OWN_P;
        end else if (x_gnt) begin
            last_owner <= OWN_X;
        end else if (p_gnt) begin
            last_owner <= OWN_P;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    always_comb begin
        x_win = 1'b0;
        p_win = 1'b0;
        if (x_lock) begin
            x_win = x_req;
        end else if (p_req && (starve_cnt == STARVE_LIM)) begin
            p_win = 1'b1;
        end else if (x_req) begin
            x_win = 1'b1;
        end else begin
            p_win = p_req;
        end
    end

    // Frozen during a locked sequence so P keeps its place once the lock drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= 4'd0;
        end else if (x_lock) begin
            starve_cnt <= starve_cnt;
        end else if (!p_req || p_gnt) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    assign x_gnt = reset_n & x_win;
    assign p_gnt = reset_n & p_win;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_owner <= OWN_X;
            alu_op   <= 10'h000;
            alu_a    <= 16'h0000;
            alu_b    <= 16'h0000;
            alu_ps   <= 8'h00;
        end else begin
            s1_valid <= x_gnt | p_gnt;
            if (x_gnt) begin
                s1_owner <= OWN_X;
                alu_op   <= x_op;
                alu_a    <= x_a;
                alu_b    <= x_b;
                alu_ps   <= x_ps;
            end else if (p_gnt) begin
                s1_owner <= OWN_P;
                alu_op   <= p_op;
                alu_a    <= p_a;
                alu_b    <= p_b;
                alu_ps   <= 8'h00;
            end
        end
    end

    // The done flops double as the stage-2 valid/owner; results hold between pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_done <= 1'b0;
            p_done <= 1'b0;
            x_d    <= 16'h0000;
            x_psr  <= 8'h00;
            p_d    <= 16'h0000;
        end else begin
            x_done <= s1_valid && (s1_owner == OWN_X);
            p_done <= s1_valid && (s1_owner == OWN_P);
            if (s1_valid && (s1_owner == OWN_X)) begin
                x_d   <= alu_d;
                x_psr <= alu_psr;
            end
            if (s1_valid && (s1_owner == OWN_P)) begin
                p_d <= alu_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: table-driven per-cycle vectors plus a reset-in-flight sequence.
// A small behavioural ALU stands in for the real one; build with ALU_ARB_RR_EN for the round-robin table.
module tb_alu_arbiter;

    localparam logic [9:0] OP_ADD  = 10'h060;
    localparam logic [9:0] OP_SUB  = 10'h160;
    localparam logic [9:0] OP_INC  = 10'h052;
    localparam logic [9:0] OP_INC2 = 10'h3f0;
    localparam logic [9:0] OP_DEC2 = 10'h3f1;
    localparam logic [9:0] OP_BR   = 10'h3f2;

    logic        clk;
    logic        reset_n;
    logic        x_req, x_lock, p_req;
    logic [9:0]  x_op, p_op;
    logic [15:0] x_a, x_b, p_a, p_b;
    logic [7:0]  x_ps;
    logic        x_gnt, x_done, p_gnt, p_done;
    logic [15:0] x_d, p_d;
    logic [7:0]  x_psr;
    logic [9:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_d;
    logic [7:0]  alu_ps, alu_psr;
    logic [16:0] alu_t;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.STARVE_MAX(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .x_req(x_req), .x_lock(x_lock), .x_op(x_op), .x_a(x_a), .x_b(x_b), .x_ps(x_ps),
        .x_gnt(x_gnt), .x_done(x_done), .x_d(x_d), .x_psr(x_psr),
        .p_req(p_req), .p_op(p_op), .p_a(p_a), .p_b(p_b),
        .p_gnt(p_gnt), .p_done(p_done), .p_d(p_d),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ps(alu_ps),
        .alu_d(alu_d), .alu_psr(alu_psr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: psr low nibble is N Z V C.
    always_comb begin
        alu_t   = 17'h0;
        alu_d   = 16'h0000;
        alu_psr = alu_ps;
        case (alu_op)
            OP_ADD: begin
                alu_t   = {1'b0, alu_a} + {1'b0, alu_b};
                alu_d   = alu_t[15:0];
                alu_psr = {alu_ps[7:4], alu_d[15], alu_d == 16'h0,
                           (alu_a[15] == alu_b[15]) && (alu_d[15] != alu_a[15]), alu_t[16]};
            end
            OP_SUB: begin
                alu_t   = {1'b0, alu_b} - {1'b0, alu_a};
                alu_d   = alu_t[15:0];
                alu_psr = {alu_ps[7:4], alu_d[15], alu_d == 16'h0,
                           (alu_a[15] != alu_b[15]) && (alu_d[15] != alu_b[15]), alu_t[16]};
            end
            OP_INC: begin
                alu_d   = alu_b + 16'h1;
                alu_psr = {alu_ps[7:4], alu_d[15], alu_d == 16'h0, alu_b == 16'h7fff, alu_ps[0]};
            end
            OP_INC2: alu_d = alu_b + 16'h2;
            OP_DEC2: alu_d = alu_b - 16'h2;
            OP_BR:   alu_d = alu_b + {{7{alu_a[7]}}, alu_a[7:0], 1'b0};
            default: alu_d = 16'h0000;
        endcase
    end

    typedef struct {
        logic        xr, xl, pr;
        logic [9:0]  xop;
        logic [15:0] xa, xb;
        logic [7:0]  xps;
        logic [9:0]  pop;
        logic [15:0] pa, pb;
        logic        gx, gp;
        logic [15:0] ed;
        logic [7:0]  epsr;
    } vec_t;

    typedef struct {
        logic        vld, own_p;
        logic [9:0]  op;
        logic [15:0] a, b, d;
        logic [7:0]  ps, psr;
    } exp_t;

    vec_t vt[$];
    exp_t exp1, exp2;

    function automatic vec_t v(input logic xr, xl, pr, input logic [9:0] xop,
                               input logic [15:0] xa, xb, input logic [7:0] xps,
                               input logic [9:0] pop, input logic [15:0] pa, pb,
                               input logic gx, gp, input logic [15:0] ed, input logic [7:0] epsr);
        vec_t r;
        r.xr = xr; r.xl = xl; r.pr = pr; r.xop = xop; r.xa = xa; r.xb = xb; r.xps = xps;
        r.pop = pop; r.pa = pa; r.pb = pb; r.gx = gx; r.gp = gp; r.ed = ed; r.epsr = epsr;
        return r;
    endfunction

    function automatic vec_t idle();
        return v(0, 0, 0, 10'h0, 16'h0, 16'h0, 8'h0, 10'h0, 16'h0, 16'h0, 0, 0, 16'h0, 8'h0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic run_cycle(input vec_t t);
        @(negedge clk);
        x_req = t.xr; x_lock = t.xl; p_req = t.pr;
        x_op = t.xop; x_a = t.xa; x_b = t.xb; x_ps = t.xps;
        p_op = t.pop; p_a = t.pa; p_b = t.pb;
        #1;
        chk("x_gnt", 32'(x_gnt), 32'(t.gx));
        chk("p_gnt", 32'(p_gnt), 32'(t.gp));
        chk("x_done", 32'(x_done), 32'(exp2.vld && !exp2.own_p));
        chk("p_done", 32'(p_done), 32'(exp2.vld && exp2.own_p));
        if (exp2.vld && !exp2.own_p) begin
            chk("x_d", 32'(x_d), 32'(exp2.d));
            chk("x_psr", 32'(x_psr), 32'(exp2.psr));
        end else if (exp2.vld) begin
            chk("p_d", 32'(p_d), 32'(exp2.d));
        end
        if (exp1.vld) begin
            chk("alu_op", 32'(alu_op), 32'(exp1.op));
            chk("alu_a", 32'(alu_a), 32'(exp1.a));
            chk("alu_b", 32'(alu_b), 32'(exp1.b));
            chk("alu_ps", 32'(alu_ps), 32'(exp1.ps));
        end
        exp2 = exp1;
        exp1.vld   = t.gx | t.gp;
        exp1.own_p = t.gp;
        exp1.op    = t.gp ? t.pop : t.xop;
        exp1.a     = t.gp ? t.pa  : t.xa;
        exp1.b     = t.gp ? t.pb  : t.xb;
        exp1.ps    = t.gp ? 8'h00 : t.xps;
        exp1.d     = t.ed;
        exp1.psr   = t.epsr;
    endtask

    initial begin
        reset_n = 1'b0;
        x_req = 1'b1; x_lock = 1'b0; p_req = 1'b1;
        x_op = OP_ADD; x_a = 16'h0; x_b = 16'h0; x_ps = 8'h0;
        p_op = OP_INC2; p_a = 16'h0; p_b = 16'h0;
        exp1 = '{default: '0};
        exp2 = '{default: '0};
        #2;
        chk("rst x_gnt", 32'(x_gnt), 32'h0);
        chk("rst p_gnt", 32'(p_gnt), 32'h0);
        chk("rst x_done", 32'(x_done), 32'h0);
        chk("rst p_done", 32'(p_done), 32'h0);
        chk("rst x_d", 32'(x_d), 32'h0);
        chk("rst x_psr", 32'(x_psr), 32'h0);
        chk("rst p_d", 32'(p_d), 32'h0);
        chk("rst alu_op", 32'(alu_op), 32'h0);
        chk("rst alu_a", 32'(alu_a), 32'h0);
        chk("rst alu_ps", 32'(alu_ps), 32'h0);
        @(negedge clk);
        reset_n = 1'b1; x_req = 1'b0; p_req = 1'b0;

        vt.push_back(idle());
        vt.push_back(v(1, 0, 0, OP_ADD, 16'h7fff, 16'h0001, 8'h00, 10'h0, 16'h0, 16'h0, 1, 0, 16'h8000, 8'h0a));
        vt.push_back(idle());
        vt.push_back(idle());
        vt.push_back(v(0, 0, 1, 10'h0, 16'h0, 16'h0, 8'h00, OP_BR, 16'h00fe, 16'h1000, 0, 1, 16'h0ffc, 8'h00));
        vt.push_back(idle());
        vt.push_back(idle());
`ifndef ALU_ARB_RR_EN
        vt.push_back(v(1, 0, 1, OP_INC, 16'h0, 16'h0010, 8'h00, OP_INC2, 16'h0, 16'h0100, 1, 0, 16'h0011, 8'h00));
        vt.push_back(v(1, 0, 1, OP_ADD, 16'hffff, 16'h0001, 8'he0, OP_INC2, 16'h0, 16'h0100, 1, 0, 16'h0000, 8'he5));
        vt.push_back(v(1, 0, 1, OP_SUB, 16'h0003, 16'h0005, 8'h00, OP_INC2, 16'h0, 16'h0100, 1, 0, 16'h0002, 8'h00));
        vt.push_back(v(1, 0, 1, OP_INC, 16'h0, 16'h0020, 8'h00, OP_INC2, 16'h0, 16'h0100, 0, 1, 16'h0102, 8'h00));
        vt.push_back(v(1, 0, 1, OP_INC, 16'h0, 16'h0020, 8'h00, OP_DEC2, 16'h0, 16'h0200, 1, 0, 16'h0021, 8'h00));
        vt.push_back(v(1, 0, 1, OP_INC, 16'h0, 16'h0030, 8'h00, OP_DEC2, 16'h0, 16'h0200, 1, 0, 16'h0031, 8'h00));
        vt.push_back(v(1, 0, 1, OP_INC, 16'h0, 16'h0040, 8'h00, OP_DEC2, 16'h0, 16'h0200, 1, 0, 16'h0041, 8'h00));
        vt.push_back(v(1, 0, 1, OP_INC, 16'h0, 16'h0050, 8'h00, OP_DEC2, 16'h0, 16'h0200, 0, 1, 16'h01fe, 8'h00));
        vt.push_back(v(1, 0, 1, OP_INC, 16'h0, 16'h0050, 8'h00, OP_INC2, 16'h0, 16'h0300, 1, 0, 16'h0051, 8'h00));
        // Ten locked cycles entered with the starvation count at 1; one of them has no X request.
        for (int k = 0; k < 10; k++) begin
            if (k == 4)
                vt.push_back(v(0, 1, 1, 10'h0, 16'h0, 16'h0, 8'h00, OP_INC2, 16'h0, 16'h0300, 0, 0, 16'h0, 8'h00));
            else
                vt.push_back(v(1, 1, 1, OP_INC, 16'h0, 16'(16'h1000 + k), 8'h00, OP_INC2, 16'h0, 16'h0300,
                               1, 0, 16'(16'h1001 + k), 8'h00));
        end
        vt.push_back(v(1, 0, 1, OP_INC, 16'h0, 16'h2000, 8'h00, OP_INC2, 16'h0, 16'h0300, 1, 0, 16'h2001, 8'h00));
        vt.push_back(v(1, 0, 1, OP_INC, 16'h0, 16'h2010, 8'h00, OP_INC2, 16'h0, 16'h0300, 1, 0, 16'h2011, 8'h00));
        vt.push_back(v(1, 0, 1, OP_INC, 16'h0, 16'h2020, 8'h00, OP_INC2, 16'h0, 16'h0300, 0, 1, 16'h0302, 8'h00));
        vt.push_back(v(1, 0, 0, OP_INC, 16'h0, 16'h2020, 8'h00, 10'h0, 16'h0, 16'h0, 1, 0, 16'h2021, 8'h00));
`else
        vt.push_back(v(1, 0, 1, OP_INC, 16'h0, 16'h0010, 8'h00, OP_INC2, 16'h0, 16'h0400, 1, 0, 16'h0011, 8'h00));
        vt.push_back(v(1, 0, 1, OP_INC, 16'h0, 16'h0020, 8'h00, OP_INC2, 16'h0, 16'h0400, 0, 1, 16'h0402, 8'h00));
        vt.push_back(v(1, 0, 1, OP_INC, 16'h0, 16'h0020, 8'h00, OP_DEC2, 16'h0, 16'h0500, 1, 0, 16'h0021, 8'h00));
        vt.push_back(v(1, 0, 1, OP_INC, 16'h0, 16'h0030, 8'h00, OP_DEC2, 16'h0, 16'h0500, 0, 1, 16'h04fe, 8'h00));
        vt.push_back(v(1, 0, 1, OP_INC, 16'h0, 16'h0030, 8'h00, OP_BR, 16'h0004, 16'h0600, 1, 0, 16'h0031, 8'h00));
        vt.push_back(v(1, 0, 1, OP_ADD, 16'h1234, 16'h1111, 8'h00, OP_BR, 16'h0004, 16'h0600, 0, 1, 16'h0608, 8'h00));
        vt.push_back(v(1, 0, 1, OP_ADD, 16'h1234, 16'h1111, 8'h00, OP_INC2, 16'h0, 16'hfffe, 1, 0, 16'h2345, 8'h00));
        vt.push_back(v(1, 0, 1, OP_SUB, 16'h0001, 16'h0001, 8'h00, OP_INC2, 16'h0, 16'hfffe, 0, 1, 16'h0000, 8'h00));
        vt.push_back(v(1, 0, 0, OP_SUB, 16'h0001, 16'h0001, 8'h00, 10'h0, 16'h0, 16'h0, 1, 0, 16'h0000, 8'h04));
        vt.push_back(idle());
        vt.push_back(v(1, 1, 1, OP_SUB, 16'h0001, 16'h0001, 8'h00, OP_INC2, 16'h0, 16'h0500, 1, 0, 16'h0000, 8'h04));
        vt.push_back(v(0, 1, 1, 10'h0, 16'h0, 16'h0, 8'h00, OP_INC2, 16'h0, 16'h0500, 0, 0, 16'h0, 8'h00));
        vt.push_back(v(1, 0, 1, OP_SUB, 16'h0002, 16'h0001, 8'h00, OP_INC2, 16'h0, 16'h0500, 0, 1, 16'h0502, 8'h00));
        vt.push_back(v(1, 0, 0, OP_SUB, 16'h0002, 16'h0001, 8'h00, 10'h0, 16'h0, 16'h0, 1, 0, 16'hffff, 8'h09));
`endif
        vt.push_back(idle());
        vt.push_back(idle());

        foreach (vt[i]) run_cycle(vt[i]);

        // Reset lands while an INC is sitting in the operand stage.
        @(negedge clk);
        x_req = 1'b1; x_lock = 1'b0; p_req = 1'b0; x_op = OP_INC; x_a = 16'h0; x_b = 16'h0005; x_ps = 8'h00;
        #1 chk("mid x_gnt", 32'(x_gnt), 32'h1);
        @(negedge clk);
        x_req = 1'b0;
        #1;
        chk("mid alu_op", 32'(alu_op), 32'(OP_INC));
        chk("mid alu_b", 32'(alu_b), 32'h0005);
        reset_n = 1'b0; x_req = 1'b1;
        #1;
        chk("mid rst alu_op", 32'(alu_op), 32'h0);
        chk("mid rst alu_b", 32'(alu_b), 32'h0);
        chk("mid rst x_d", 32'(x_d), 32'h0);
        chk("mid rst x_psr", 32'(x_psr), 32'h0);
        chk("mid rst p_d", 32'(p_d), 32'h0);
        chk("mid rst x_gnt", 32'(x_gnt), 32'h0);
        chk("mid rst x_done", 32'(x_done), 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                reset_n = 1'b1; x_req = 1'b0;
            end
            #1;
            chk("post rst x_done", 32'(x_done), 32'h0);
            chk("post rst p_done", 32'(p_done), 32'h0);
        end
        @(negedge clk);
        x_req = 1'b1; x_op = OP_INC; x_b = 16'h0007;
        #1 chk("fresh x_gnt", 32'(x_gnt), 32'h1);
        @(negedge clk);
        x_req = 1'b0;
        #1 chk("fresh x_done early", 32'(x_done), 32'h0);
        @(negedge clk);
        #1;
        chk("fresh x_done", 32'(x_done), 32'h1);
        chk("fresh x_d", 32'(x_d), 32'h0008);
        chk("fresh x_psr", 32'(x_psr), 32'h00);
        @(negedge clk);
        #1 chk("fresh x_done pulse", 32'(x_done), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
